// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Two-requester arbiter in front of a single-ported synchronous RAM.
// A request is granted only in IDLE. The granted access is then driven onto
// the RAM for exactly one cycle (ACC). A read then waits in RSP until the RAM
// data is valid and delivers it to the owning requester.
// Ties are broken round-robin using the last winner.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   hold_i                  blocks new grants; an in-flight access completes
//   mN_req_i/we_i/addr_i/wdata_i   requester N access request fields
//   mN_gnt_o                one-cycle grant pulse (combinational, IDLE only)
//   mN_rvalid_o/rdata_o     read-data-valid pulse and held read data
//   ram_adr_o/wen_o/dat_o   shared RAM address, write enable, write data
//   ram_dat_i               RAM read data, READ_LAT cycles after the address
//   busy_o                  high in any state other than IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              hold_i,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic [ADDR_W-1:0] ram_adr_o,
   output logic              ram_wen_o,
   output logic [DATA_W-1:0] ram_dat_o,
   input  logic [DATA_W-1:0] ram_dat_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

   // Extra RSP cycles to wait before the RAM data is valid.
   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;

   logic grantAllowed;
   logic pick1;
   logic rspDone;

   // Grant decision. On a tie m1 wins only when m0 won last time.
   // Grants are suppressed while reset is asserted.
   assign grantAllowed = (state_q == IDLE) && !hold_i && !reset_i;
   assign pick1        = m1_req_i && (!m0_req_i || !last_q);
   assign m0_gnt_o     = grantAllowed && m0_req_i && !pick1;
   assign m1_gnt_o     = grantAllowed && pick1;

   // Read completion is flagged in the last RSP cycle.
   // The RAM data is forwarded straight through so rdata and rvalid line up.
   assign rspDone      = (state_q == RSP) && (cnt_q == 2'd0) && !reset_i;
   assign m0_rvalid_o  = rspDone && !owner_q;
   assign m1_rvalid_o  = rspDone && owner_q;
   assign m0_rdata_o   = m0_rvalid_o ? ram_dat_i : rdata0_q;
   assign m1_rdata_o   = m1_rvalid_o ? ram_dat_i : rdata1_q;

   // The address and data registers only change at a grant.
   // They therefore hold their last values outside ACC without extra muxing.
   assign ram_adr_o    = adr_q;
   assign ram_dat_o    = dat_q;
   assign ram_wen_o    = (state_q == ACC) && we_q && !reset_i;
   assign busy_o       = (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      cnt_d    = cnt_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (m0_gnt_o || m1_gnt_o) begin
               state_d = ACC;
               owner_d = pick1;
               last_d  = pick1;
               we_d    = pick1 ? m1_we_i    : m0_we_i;
               adr_d   = pick1 ? m1_addr_i  : m0_addr_i;
               dat_d   = pick1 ? m1_wdata_i : m0_wdata_i;
            end
         end
         ACC: begin
            state_d = we_q ? IDLE : RSP;
            cnt_d   = LAT_M1;
         end
         RSP: begin
            if (cnt_q == 2'd0) begin
               state_d = IDLE;
               if (owner_q) rdata1_d = ram_dat_i;
               else         rdata0_d = ram_dat_i;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset aborts any in-flight access.
   // It also leaves m0 the winner of the first tie.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         cnt_q    <= 2'd0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         cnt_q    <= cnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench for mem_port_arbiter.
// The stimulus process drives one cycle at a time. It decides from the
// arbitration rules which requester should be granted, and when. It then
// queues the expected grant, RAM write and read response.
// A negedge monitor pops those queues whenever the DUT presents an output.
// A small RAM with READ_LAT registered stages feeds ram_dat_i.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int LAT = 1;

   typedef struct {
      int          cyc;
      int          owner;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        hold;
   logic        req [2];
   logic        we [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        gnt [2];
   logic        rvalid [2];
   logic [31:0] rdata [2];
   logic [31:0] ramAdr;
   logic        ramWen;
   logic [31:0] ramDatO;
   logic [31:0] ramDatI;
   logic        busy;

   // Environment RAM (written by the DUT) and the model's view of it.
   logic [31:0] physMem [64];
   logic [31:0] modelMem [64];
   logic [31:0] pipe [LAT];

   int   cyc = 0;
   int   assertions = 0;
   int   failures = 0;
   bit   monEn = 1'b0;
   bit   randomMode = 1'b0;
   bit   keepReq = 1'b0;

   // Model state.
   exp_t gntQ[$];
   exp_t wrQ[$];
   exp_t rdQ[$];
   int   nextFree = 0;
   int   mLast = 1;
   bit   pendValid = 1'b0;
   int   pendCyc = 0;
   logic [31:0] pendAddr, pendData;
   bit   expBusy [int];
   bit   postReset [int];
   bit   dropNext [2];
   bit   pSet [2];
   logic pWe [2];
   logic [31:0] pAddr [2];
   logic [31:0] pData [2];
   logic [31:0] held [2];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(LAT)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .hold_i     (hold),
      .m0_req_i   (req[0]),
      .m0_we_i    (we[0]),
      .m0_addr_i  (addr[0]),
      .m0_wdata_i (wdata[0]),
      .m0_gnt_o   (gnt[0]),
      .m0_rvalid_o(rvalid[0]),
      .m0_rdata_o (rdata[0]),
      .m1_req_i   (req[1]),
      .m1_we_i    (we[1]),
      .m1_addr_i  (addr[1]),
      .m1_wdata_i (wdata[1]),
      .m1_gnt_o   (gnt[1]),
      .m1_rvalid_o(rvalid[1]),
      .m1_rdata_o (rdata[1]),
      .ram_adr_o  (ramAdr),
      .ram_wen_o  (ramWen),
      .ram_dat_o  (ramDatO),
      .ram_dat_i  (ramDatI),
      .busy_o     (busy)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM with LAT registered read stages.
   always @(posedge clk) begin
      if (ramWen) physMem[ramAdr[5:0]] <= ramDatO;
      pipe[0] <= physMem[ramAdr[5:0]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign ramDatI = pipe[LAT-1];

   // Records one comparison and reports it on failure.
   task automatic checkOutput(input bit ok, input string name, input string got, input string want);
      assertions++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %s, expected %s", name, cyc, got, want);
      end
   endtask

   // Queues a new request for requester n, applied at the start of the next cycle.
   task automatic setReq(input int n, input logic w, input logic [31:0] a, input logic [31:0] d);
      pSet[n]  = 1'b1;
      pWe[n]   = w;
      pAddr[n] = a;
      pData[n] = d;
   endtask

   // One clock cycle: apply inputs just after the edge.
   // Then decide from the arbitration rules what the DUT must do this cycle.
   task automatic applyStimulus(input logic rst, input logic hld);
      int w;
      exp_t e;
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
         if (dropNext[n]) begin
            req[n] = 1'b0;
            dropNext[n] = 1'b0;
         end
         if (pSet[n]) begin
            req[n] = 1'b1; we[n] = pWe[n]; addr[n] = pAddr[n]; wdata[n] = pData[n];
            pSet[n] = 1'b0;
         end
         if (randomMode) begin
            if (!req[n] && $urandom_range(0, 99) < 40) begin
               req[n] = 1'b1;
               we[n] = 1'($urandom_range(0, 1));
               addr[n] = 32'($urandom_range(0, 63));
               wdata[n] = $urandom;
            end else if (req[n] && $urandom_range(0, 99) < 4) begin
               req[n] = 1'b0;
            end
         end
      end
      reset = rst;
      hold  = hld;

      expBusy[cyc] = (cyc < nextFree);
      if (rst) begin
         gntQ.delete(); wrQ.delete(); rdQ.delete();
         pendValid = 1'b0;
         mLast = 1;
         nextFree = cyc + 1;
         postReset[cyc+1] = 1'b1;
      end else begin
         if (pendValid && pendCyc == cyc) begin
            modelMem[pendAddr[5:0]] = pendData;
            pendValid = 1'b0;
         end
         if (cyc >= nextFree && !hld && (req[0] || req[1])) begin
            if (req[0] && req[1]) w = (mLast == 0) ? 1 : 0;
            else w = req[1] ? 1 : 0;
            mLast = w;
            e.cyc = cyc; e.owner = w; e.addr = addr[w]; e.data = 32'h0;
            gntQ.push_back(e);
            if (we[w]) begin
               e.cyc = cyc + 1; e.data = wdata[w];
               wrQ.push_back(e);
               pendValid = 1'b1; pendCyc = cyc + 1; pendAddr = addr[w]; pendData = wdata[w];
               nextFree = cyc + 2;
            end else begin
               e.cyc = cyc + 1 + LAT; e.data = modelMem[addr[w][5:0]];
               rdQ.push_back(e);
               nextFree = cyc + 2 + LAT;
            end
            if (!keepReq) dropNext[w] = 1'b1;
         end
      end
   endtask

   // Runs cycles until all requests are served and the model is idle again.
   task automatic runUntilIdle(input int maxc);
      int k = 0;
      while (k < maxc && (req[0] || req[1] || pSet[0] || pSet[1] || cyc <= nextFree)) begin
         applyStimulus(1'b0, 1'b0);
         k++;
      end
      if (k >= maxc) checkOutput(1'b0, "idle_timeout", "still busy", "idle");
   endtask

   // Monitor: compare DUT outputs against the expected-event queues.
   always @(negedge clk) begin
      exp_t e;
      bit   expNow;
      bit   ok;
      if (monEn) begin
         if (postReset.exists(cyc)) begin
            held[0] = 32'h0;
            held[1] = 32'h0;
            checkOutput(ramAdr == 32'h0 && ramDatO == 32'h0, "reset_ram_bus",
                        $sformatf("adr=%h dat=%h", ramAdr, ramDatO), "adr=0 dat=0");
         end

         checkOutput(!(gnt[0] && gnt[1]), "gnt_onehot", $sformatf("%b%b", gnt[1], gnt[0]), "at most one");
         expNow = gntQ.size() > 0 && gntQ[0].cyc == cyc;
         if (expNow || gnt[0] || gnt[1]) begin
            ok = expNow && (gntQ[0].owner == 1 ? (gnt[1] && !gnt[0]) : (gnt[0] && !gnt[1]));
            checkOutput(ok, "grant", $sformatf("gnt=%b%b", gnt[1], gnt[0]),
                        expNow ? $sformatf("m%0d", gntQ[0].owner) : "none");
            if (expNow) void'(gntQ.pop_front());
         end

         expNow = wrQ.size() > 0 && wrQ[0].cyc == cyc;
         if (expNow || ramWen) begin
            if (expNow) e = wrQ.pop_front();
            ok = expNow && ramWen && ramAdr == e.addr && ramDatO == e.data;
            checkOutput(ok, "ram_write", $sformatf("wen=%b adr=%h dat=%h", ramWen, ramAdr, ramDatO),
                        expNow ? $sformatf("wen=1 adr=%h dat=%h", e.addr, e.data) : "wen=0");
         end

         expNow = rdQ.size() > 0 && rdQ[0].cyc == cyc;
         if (expNow || rvalid[0] || rvalid[1]) begin
            if (expNow) e = rdQ.pop_front();
            ok = expNow && rvalid[e.owner] && !rvalid[1-e.owner] && rdata[e.owner] == e.data;
            checkOutput(ok, "read_resp",
                        $sformatf("rvalid=%b%b rdata0=%h rdata1=%h", rvalid[1], rvalid[0], rdata[0], rdata[1]),
                        expNow ? $sformatf("m%0d data=%h", e.owner, e.data) : "no rvalid");
            if (expNow) held[e.owner] = e.data;
         end

         for (int n = 0; n < 2; n++) begin
            if (!rvalid[n])
               checkOutput(rdata[n] == held[n], $sformatf("rdata_hold_m%0d", n),
                           $sformatf("%h", rdata[n]), $sformatf("%h", held[n]));
         end

         if (expBusy.exists(cyc))
            checkOutput(busy == expBusy[cyc], "busy", $sformatf("%b", busy), $sformatf("%b", expBusy[cyc]));
      end
   end

   initial begin
      reset = 1'b1;
      hold  = 1'b0;
      for (int n = 0; n < 2; n++) begin
         req[n] = 1'b0; we[n] = 1'b0; addr[n] = 32'h0; wdata[n] = 32'h0;
         dropNext[n] = 1'b0; pSet[n] = 1'b0; held[n] = 32'h0;
      end
      for (int i = 0; i < 64; i++) begin
         physMem[i] <= 32'hA5A5_0000 ^ (i * 32'h0101_0101);
         modelMem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      end

      // Reset, then start monitoring once the DUT state is defined.
      repeat (2) applyStimulus(1'b1, 1'b0);
      monEn = 1'b1;
      applyStimulus(1'b1, 1'b0);

      // Single write, then a write/read pair through the same address.
      setReq(0, 1'b1, 32'h10, 32'hDEADBEEF);
      runUntilIdle(20);
      setReq(0, 1'b1, 32'h20, 32'h1234_5678);
      runUntilIdle(20);
      setReq(1, 1'b0, 32'h20, 32'h0);
      runUntilIdle(20);

      // Tie after reset: both requesters hold reads continuously for 4 grants.
      applyStimulus(1'b1, 1'b0);
      setReq(0, 1'b0, 32'h10, 32'h0);
      setReq(1, 1'b0, 32'h20, 32'h0);
      keepReq = 1'b1;
      repeat (4 * (LAT + 2)) applyStimulus(1'b0, 1'b0);
      keepReq = 1'b0;
      dropNext[0] = 1'b1;
      dropNext[1] = 1'b1;
      runUntilIdle(20);

      // Hold blocks a pending request for 5 cycles, then it is granted at once.
      setReq(0, 1'b1, 32'h30, 32'hCAFE_F00D);
      repeat (5) applyStimulus(1'b0, 1'b1);
      runUntilIdle(20);

      // Hold raised during a read must not disturb it.
      setReq(0, 1'b0, 32'h30, 32'h0);
      applyStimulus(1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b1);
      runUntilIdle(20);

      // Reset during the response phase aborts the read; m0 then wins a tie.
      setReq(1, 1'b0, 32'h20, 32'h0);
      repeat (1 + LAT) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      setReq(0, 1'b0, 32'h10, 32'h0);
      setReq(1, 1'b0, 32'h20, 32'h0);
      runUntilIdle(40);

      // Randomized traffic with random hold, withdrawals and occasional reset.
      randomMode = 1'b1;
      repeat (3000) applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0));
      randomMode = 1'b0;
      dropNext[0] = 1'b1;
      dropNext[1] = 1'b1;
      runUntilIdle(40);
      repeat (5) applyStimulus(1'b0, 1'b0);

      checkOutput(gntQ.size() == 0 && wrQ.size() == 0 && rdQ.size() == 0, "queues_drained",
                  $sformatf("gnt=%0d wr=%0d rd=%0d left", gntQ.size(), wrQ.size(), rdQ.size()), "all empty");

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
